// File: rtl/demux_1_4_buf_if.sv
// Handshake bundle for demux_1_4_buf: one input stream, four output channels.
// o_acc_cnt exists only when DEMUX_1_4_CNT_EN is defined.
interface demux_1_4_buf_if #(
    parameter int DW     = 4,
    parameter int DW_SEL = 2
);
    logic [DW-1:0]     i_data;
    logic [DW_SEL-1:0] i_sel;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     o_a;
    logic [DW-1:0]     o_b;
    logic [DW-1:0]     o_c;
    logic [DW-1:0]     o_d;
    logic              o_valid_a;
    logic              o_valid_b;
    logic              o_valid_c;
    logic              o_valid_d;
    logic              i_ready_a;
    logic              i_ready_b;
    logic              i_ready_c;
    logic              i_ready_d;
`ifdef DEMUX_1_4_CNT_EN
    logic [7:0]        o_acc_cnt;
`endif

    modport master (
        output i_data, i_sel, i_valid,
        output i_ready_a, i_ready_b, i_ready_c, i_ready_d,
        input  o_ready,
        input  o_a, o_b, o_c, o_d,
        input  o_valid_a, o_valid_b, o_valid_c, o_valid_d
`ifdef DEMUX_1_4_CNT_EN
        , input o_acc_cnt
`endif
    );

    modport slave (
        input  i_data, i_sel, i_valid,
        input  i_ready_a, i_ready_b, i_ready_c, i_ready_d,
        output o_ready,
        output o_a, o_b, o_c, o_d,
        output o_valid_a, o_valid_b, o_valid_c, o_valid_d
`ifdef DEMUX_1_4_CNT_EN
        , output o_acc_cnt
`endif
    );
endinterface

// File: rtl/demux_1_4_buf.sv
// 1-to-4 buffered demux, one holding register per channel, valid/ready.
// Optional accepted-word counter under DEMUX_1_4_CNT_EN.
module demux_1_4_buf #(
    parameter int DW     = 4,
    parameter int DW_SEL = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    demux_1_4_buf_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e         st_q  [4];
    slot_e         st_d  [4];
    logic [DW-1:0] dat_q [4];
    logic [DW-1:0] dat_d [4];

    logic [3:0] tgt;
    logic [3:0] take;
    logic [3:0] full;
    logic [3:0] acc_oh;
    logic       acc;

    // Any select value of 3 or above lands on channel d.
    always_comb begin
        tgt = 4'b0000;
        unique case (1'b1)
            (bus.i_sel == DW_SEL'(0)): tgt = 4'b0001;
            (bus.i_sel == DW_SEL'(1)): tgt = 4'b0010;
            (bus.i_sel == DW_SEL'(2)): tgt = 4'b0100;
            default:                   tgt = 4'b1000;
        endcase
    end

    assign take = {bus.i_ready_d, bus.i_ready_c,
                   bus.i_ready_b, bus.i_ready_a};

    always_comb begin
        full = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            full[i] = (st_q[i] == FULL);
        end
    end

    assign bus.o_ready = |(tgt & (~full | take));
    assign acc         = bus.i_valid & bus.o_ready;
    assign acc_oh      = tgt & {4{acc}};

    // A fill wins over a drain, so drain+fill keeps the slot FULL.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            dat_d[i] = dat_q[i];
            if (acc_oh[i]) begin
                st_d[i]  = FULL;
                dat_d[i] = bus.i_data;
            end else if (st_q[i] == FULL && take[i]) begin
                st_d[i]  = EMPTY;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= EMPTY;
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign bus.o_a       = dat_q[0];
    assign bus.o_b       = dat_q[1];
    assign bus.o_c       = dat_q[2];
    assign bus.o_d       = dat_q[3];
    assign bus.o_valid_a = full[0];
    assign bus.o_valid_b = full[1];
    assign bus.o_valid_c = full[2];
    assign bus.o_valid_d = full[3];

`ifdef DEMUX_1_4_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 8'h00;
        end else if (acc && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.o_acc_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Scoreboard bench for demux_1_4_buf: per-channel expected queues.
// Second instance with DW_SEL=3 checks wide-select routing to d.
module tb_demux_1_4_buf;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    demux_1_4_buf_if #(.DW(4), .DW_SEL(2)) bus ();
    demux_1_4_buf_if #(.DW(4), .DW_SEL(3)) bus2 ();

    demux_1_4_buf #(.DW(4), .DW_SEL(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    demux_1_4_buf #(.DW(4), .DW_SEL(3)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2.slave)
    );

    logic [3:0] od [4];
    logic [3:0] ov;
    assign od[0] = bus.o_a;
    assign od[1] = bus.o_b;
    assign od[2] = bus.o_c;
    assign od[3] = bus.o_d;
    assign ov = {bus.o_valid_d, bus.o_valid_c,
                 bus.o_valid_b, bus.o_valid_a};

    logic [3:0] sb [4][$];
    int         n_chk = 0;
    int         n_err = 0;
    int         exp_cnt = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        {bus.i_ready_d, bus.i_ready_c,
         bus.i_ready_b, bus.i_ready_a} = 4'b0000;
        bus2.i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int x = 0; x < 4; x++) begin
            sb[x].delete();
            chk($sformatf("rst_valid%0d", x), ov[x], 0);
            chk($sformatf("rst_data%0d", x), od[x], 0);
        end
        chk("rst_ready", bus.o_ready, 1);
        chk("rst2_valid_d", bus2.o_valid_d, 0);
        exp_cnt = 0;
`ifdef DEMUX_1_4_CNT_EN
        chk("rst_cnt", bus.o_acc_cnt, 0);
`endif
    endtask

    task automatic step(input int sel, input logic [3:0] d,
                        input logic v, input logic [3:0] rdy);
        int   t;
        logic er;
        @(negedge clk);
        bus.i_sel   = 2'(sel);
        bus.i_data  = d;
        bus.i_valid = v;
        {bus.i_ready_d, bus.i_ready_c,
         bus.i_ready_b, bus.i_ready_a} = rdy;
        #1;
        t  = (sel >= 3) ? 3 : sel;
        er = (sb[t].size() == 0) || rdy[t];
        chk($sformatf("ready_sel%0d", sel), bus.o_ready, er);
        for (int x = 0; x < 4; x++) begin
            chk($sformatf("valid%0d", x), ov[x], sb[x].size() != 0);
            if (sb[x].size() != 0) begin
                chk($sformatf("data%0d", x), od[x], sb[x][0]);
                if (rdy[x]) void'(sb[x].pop_front());
            end
        end
        if (v && er) begin
            sb[t].push_back(d);
            if (exp_cnt < 255) exp_cnt++;
        end
        @(posedge clk);
    endtask

    initial begin
        bus.i_sel = '0;
        bus.i_data = '0;
        bus.i_valid = 1'b0;
        {bus.i_ready_d, bus.i_ready_c,
         bus.i_ready_b, bus.i_ready_a} = 4'b0000;
        bus2.i_sel = '0;
        bus2.i_data = '0;
        bus2.i_valid = 1'b0;
        {bus2.i_ready_d, bus2.i_ready_c,
         bus2.i_ready_b, bus2.i_ready_a} = 4'b0000;

        do_reset();

        step(2, 4'hA, 1'b1, 4'b0000);
        step(0, 4'h0, 1'b0, 4'b0000);
        chk("t1_c", bus.o_c, 4'hA);
        chk("t1_others", {bus.o_valid_a, bus.o_valid_b, bus.o_valid_d}, 0);

        step(1, 4'h3, 1'b1, 4'b0000);
        step(1, 4'h9, 1'b1, 4'b0000);
        chk("t2_b_hold", bus.o_b, 4'h3);
        step(0, 4'h6, 1'b1, 4'b0000);

        step(1, 4'h7, 1'b1, 4'b0010);
        step(0, 4'h0, 1'b0, 4'b0000);
        chk("t3_b", bus.o_b, 4'h7);
        chk("t3_vb", bus.o_valid_b, 1);

        step(3, 4'hC, 1'b1, 4'b0000);
        step(0, 4'h0, 1'b0, 4'b0000);
        chk("t5_all_full", ov, 4'b1111);
        do_reset();

        @(negedge clk);
        bus2.i_sel = 3'd6;
        bus2.i_data = 4'h5;
        bus2.i_valid = 1'b1;
        #1;
        chk("t4_ready", bus2.o_ready, 1);
        @(posedge clk);
        #1;
        chk("t4_d", bus2.o_d, 4'h5);
        chk("t4_vd", bus2.o_valid_d, 1);
        chk("t4_vabc", {bus2.o_valid_a, bus2.o_valid_b, bus2.o_valid_c}, 0);
        @(negedge clk);
        bus2.i_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 3)), 4'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom));
        end
        step(0, 4'h0, 1'b0, 4'b0000);
`ifdef DEMUX_1_4_CNT_EN
        chk("rand_cnt", bus.o_acc_cnt, exp_cnt);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 3)), 4'($urandom), 1'b1, 4'b1111);
        end
        step(0, 4'h0, 1'b0, 4'b1111);
        chk("t6_cnt_exp", exp_cnt, 255);
        chk("t6_cnt", bus.o_acc_cnt, 8'hFF);
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
